// File: rtl/roce_tx_segment_header.sv
// RoCE TX segment header generator.
// Emits one BTH/RETH/ImmDt header per PMTU segment, then forwards its payload.
module roce_tx_segment_header #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_dma_meta_valid,
  output logic                    s_dma_meta_ready,
  input  logic [31:0]             s_dma_length,
  input  logic [23:0]             s_rem_qpn,
  input  logic [23:0]             s_rem_psn,
  input  logic [31:0]             s_r_key,
  input  logic [31:0]             s_rem_ip_addr,
  input  logic [63:0]             s_rem_addr,
  input  logic                    s_is_immediate,
  input  logic [31:0]             s_immediate_data,
  input  logic                    s_trasfer_type,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [14:0]             s_axis_tuser,
  output logic                    s_axis_tready,
  output logic                    m_hdr_valid,
  input  logic                    m_hdr_ready,
  output logic [7:0]              m_hdr_opcode,
  output logic [23:0]             m_hdr_psn,
  output logic [23:0]             m_hdr_dest_qp,
  output logic [31:0]             m_hdr_ip_addr,
  output logic [12:0]             m_hdr_seg_length,
  output logic                    m_hdr_has_reth,
  output logic [63:0]             m_hdr_reth_vaddr,
  output logic [31:0]             m_hdr_reth_rkey,
  output logic [31:0]             m_hdr_reth_length,
  output logic                    m_hdr_has_immdt,
  output logic [31:0]             m_hdr_immdt,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tuser
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEG_WAIT = 2'd1;
  localparam logic [1:0] HDR      = 2'd2;
  localparam logic [1:0] PAYLOAD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        rdy_q;
  logic        type_q, imm_q;
  logic [31:0] immd_q, len_q, rkey_q, ip_q;
  logic [23:0] qpn_q, psn_q;
  logic [63:0] addr_q, off_q, va_q;
  logic        first_q;
  logic [7:0]  op_q, op_d;
  logic [12:0] seg_len_q;
  logic        seg_last_q, reth_q, immf_q;

  logic meta_fire, hdr_fire, beat_fire, last_fire;
  logic seg_last;

  assign seg_last  = s_axis_tuser[1];
  assign meta_fire = s_dma_meta_valid & s_dma_meta_ready;
  assign hdr_fire  = m_hdr_valid & m_hdr_ready;
  assign beat_fire = m_axis_tvalid & m_axis_tready;
  assign last_fire = beat_fire & s_axis_tlast;

  // rdy_q keeps meta_ready low while reset is held, rising one edge later
  assign s_dma_meta_ready = rdy_q & (state_q == IDLE);
  assign m_hdr_valid      = (state_q == HDR);
  assign s_axis_tready    = (state_q == PAYLOAD) & m_axis_tready;
  assign m_axis_tvalid    = (state_q == PAYLOAD) & s_axis_tvalid;
  assign m_axis_tdata     = s_axis_tdata;
  assign m_axis_tkeep     = s_axis_tkeep;
  assign m_axis_tlast     = s_axis_tlast;
  assign m_axis_tuser     = s_axis_tuser[0];

  assign m_hdr_opcode      = op_q;
  assign m_hdr_psn         = psn_q;
  assign m_hdr_dest_qp     = qpn_q;
  assign m_hdr_ip_addr     = ip_q;
  assign m_hdr_seg_length  = seg_len_q;
  assign m_hdr_has_reth    = reth_q;
  assign m_hdr_reth_vaddr  = va_q;
  assign m_hdr_reth_rkey   = rkey_q;
  assign m_hdr_reth_length = len_q;
  assign m_hdr_has_immdt   = immf_q;
  assign m_hdr_immdt       = immd_q;

  // Next-state selection for the segment walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (meta_fire) state_d = SEG_WAIT;
      SEG_WAIT: if (s_axis_tvalid) state_d = HDR;
      HDR:      if (hdr_fire) state_d = PAYLOAD;
      PAYLOAD: begin
        if (last_fire) state_d = seg_last_q ? IDLE : SEG_WAIT;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Opcode from segment position, transfer type and immediate flag
  always_comb begin
    op_d = 8'h00;
    case ({first_q, seg_last})
      2'b11: op_d = type_q ? (imm_q ? 8'h0B : 8'h0A)
                           : (imm_q ? 8'h05 : 8'h04);
      2'b10: op_d = type_q ? 8'h06 : 8'h00;
      2'b00: op_d = type_q ? 8'h07 : 8'h01;
      default: op_d = type_q ? (imm_q ? 8'h09 : 8'h08)
                             : (imm_q ? 8'h03 : 8'h02);
    endcase
  end

  // State register and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Latch per-transfer metadata on the meta handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q <= 1'b0;
      imm_q  <= 1'b0;
      immd_q <= '0;
      len_q  <= '0;
      rkey_q <= '0;
      ip_q   <= '0;
      qpn_q  <= '0;
      addr_q <= '0;
    end else if (meta_fire) begin
      type_q <= s_trasfer_type;
      imm_q  <= s_is_immediate;
      immd_q <= s_immediate_data;
      len_q  <= s_dma_length;
      rkey_q <= s_r_key;
      ip_q   <= s_rem_ip_addr;
      qpn_q  <= s_rem_qpn;
      addr_q <= s_rem_addr;
    end
  end

  // Segment walk: psn, byte offset and first-segment tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psn_q   <= '0;
      off_q   <= '0;
      first_q <= 1'b1;
    end else if (meta_fire) begin
      psn_q   <= s_rem_psn;
      off_q   <= '0;
      first_q <= 1'b1;
    end else begin
      if (hdr_fire) psn_q <= psn_q + 24'd1;
      if (state_q == PAYLOAD && last_fire) begin
        off_q   <= off_q + {51'd0, seg_len_q};
        first_q <= 1'b0;
      end
    end
  end

  // Capture header fields from the first visible beat of a segment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      seg_len_q  <= '0;
      seg_last_q <= 1'b0;
      reth_q     <= 1'b0;
      immf_q     <= 1'b0;
      va_q       <= '0;
    end else if (state_q == SEG_WAIT && s_axis_tvalid) begin
      op_q       <= op_d;
      seg_len_q  <= s_axis_tuser[14:2];
      seg_last_q <= seg_last;
      reth_q     <= type_q & first_q;
      immf_q     <= imm_q & seg_last;
      va_q       <= addr_q + off_q;
    end
  end

endmodule

// File: tb/tb_roce_tx_segment_header.sv
// Randomized bench for roce_tx_segment_header.
// Expected headers and beats come from a transfer-level segmentation model.
module tb_roce_tx_segment_header;

  localparam int DW = 64;
  localparam int B  = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_dma_meta_valid = 1'b0;
  logic          s_dma_meta_ready;
  logic [31:0]   s_dma_length = '0;
  logic [23:0]   s_rem_qpn = '0;
  logic [23:0]   s_rem_psn = '0;
  logic [31:0]   s_r_key = '0;
  logic [31:0]   s_rem_ip_addr = '0;
  logic [63:0]   s_rem_addr = '0;
  logic          s_is_immediate = 1'b0;
  logic [31:0]   s_immediate_data = '0;
  logic          s_trasfer_type = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [7:0]    s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [14:0]   s_axis_tuser = '0;
  logic          s_axis_tready;
  logic          m_hdr_valid;
  logic          m_hdr_ready = 1'b0;
  logic [7:0]    m_hdr_opcode;
  logic [23:0]   m_hdr_psn;
  logic [23:0]   m_hdr_dest_qp;
  logic [31:0]   m_hdr_ip_addr;
  logic [12:0]   m_hdr_seg_length;
  logic          m_hdr_has_reth;
  logic [63:0]   m_hdr_reth_vaddr;
  logic [31:0]   m_hdr_reth_rkey;
  logic [31:0]   m_hdr_reth_length;
  logic          m_hdr_has_immdt;
  logic [31:0]   m_hdr_immdt;
  logic [DW-1:0] m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tuser;

  roce_tx_segment_header #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_dma_meta_valid(s_dma_meta_valid),
    .s_dma_meta_ready(s_dma_meta_ready),
    .s_dma_length(s_dma_length), .s_rem_qpn(s_rem_qpn),
    .s_rem_psn(s_rem_psn), .s_r_key(s_r_key),
    .s_rem_ip_addr(s_rem_ip_addr), .s_rem_addr(s_rem_addr),
    .s_is_immediate(s_is_immediate),
    .s_immediate_data(s_immediate_data),
    .s_trasfer_type(s_trasfer_type),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_opcode(m_hdr_opcode), .m_hdr_psn(m_hdr_psn),
    .m_hdr_dest_qp(m_hdr_dest_qp), .m_hdr_ip_addr(m_hdr_ip_addr),
    .m_hdr_seg_length(m_hdr_seg_length),
    .m_hdr_has_reth(m_hdr_has_reth),
    .m_hdr_reth_vaddr(m_hdr_reth_vaddr),
    .m_hdr_reth_rkey(m_hdr_reth_rkey),
    .m_hdr_reth_length(m_hdr_reth_length),
    .m_hdr_has_immdt(m_hdr_has_immdt), .m_hdr_immdt(m_hdr_immdt),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [12:0] len;
    logic        reth;
    logic [63:0] va;
    logic        immf;
  } hdr_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [14:0] user;
  } beat_t;

  hdr_t  exp_hdr[$];
  beat_t exp_beats[$];
  beat_t src_beats[$];

  int tests = 0;
  int fails = 0;
  int stall_left = 0;

  logic [23:0] g_qpn;
  logic [31:0] g_ip, g_rkey, g_len, g_immd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Split a transfer into PMTU segments and derive headers and beats
  task automatic build_model(input bit wr, input int unsigned len,
                             input int unsigned pmtu,
                             input logic [23:0] psn,
                             input logic [63:0] addr, input bit imm);
    int unsigned nseg;
    nseg = (len == 0) ? 1 : (len + pmtu - 1) / pmtu;
    for (int unsigned i = 0; i < nseg; i++) begin
      hdr_t h;
      int unsigned sl, nb;
      bit f, l;
      f  = (i == 0);
      l  = (i == nseg - 1);
      sl = l ? len - i * pmtu : pmtu;
      if (f && l)
        h.op = wr ? (imm ? 8'h0B : 8'h0A) : (imm ? 8'h05 : 8'h04);
      else if (f)
        h.op = wr ? 8'h06 : 8'h00;
      else if (l)
        h.op = (wr ? 8'h08 : 8'h02) + {7'd0, imm};
      else
        h.op = wr ? 8'h07 : 8'h01;
      h.psn  = psn + 24'(i);
      h.len  = 13'(sl);
      h.reth = wr && f;
      h.va   = addr + 64'(i * pmtu);
      h.immf = imm && l;
      exp_hdr.push_back(h);
      nb = (sl == 0) ? 1 : (sl + 7) / 8;
      for (int unsigned b = 0; b < nb; b++) begin
        beat_t bt;
        bt.data = '0;
        bt.keep = '0;
        for (int k = 0; k < 8; k++) begin
          if (b * 8 + k < sl) begin
            bt.keep[k] = 1'b1;
            bt.data[k*8 +: 8] = 8'($urandom_range(255));
          end
        end
        bt.last = (b == nb - 1);
        bt.user = {13'(sl), l, 1'($urandom_range(1))};
        exp_beats.push_back(bt);
        src_beats.push_back(bt);
      end
    end
  endtask

  task automatic meta_drv(input bit wr, input int unsigned len,
                          input logic [23:0] psn,
                          input logic [63:0] addr, input bit imm);
    bit acc = 0;
    int c = 0;
    s_dma_meta_valid = 1'b1;
    s_trasfer_type   = wr;
    s_dma_length     = len;
    s_rem_psn        = psn;
    s_rem_addr       = addr;
    s_is_immediate   = imm;
    s_immediate_data = g_immd;
    s_rem_qpn        = g_qpn;
    s_rem_ip_addr    = g_ip;
    s_r_key          = g_rkey;
    while (!acc && c < B) begin
      #1;
      acc = s_dma_meta_ready;
      @(negedge clk);
      c++;
    end
    s_dma_meta_valid = 1'b0;
    chk("meta_accept", 64'(acc), 64'd1);
  endtask

  task automatic src_drv();
    bit ok = 1;
    while (src_beats.size() > 0 && ok) begin
      beat_t bt;
      bit acc = 0;
      int c = 0;
      bt = src_beats.pop_front();
      if ($urandom_range(3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bt.data;
      s_axis_tkeep  = bt.keep;
      s_axis_tlast  = bt.last;
      s_axis_tuser  = bt.user;
      while (!acc && c < B) begin
        #1;
        acc = s_axis_tready;
        @(negedge clk);
        c++;
      end
      if (!acc) begin
        chk("src_timeout", 64'(acc), 64'd1);
        ok = 0;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic hdr_sink();
    bit held = 0;
    logic [63:0] sva = '0;
    logic [46:0] smisc = '0;
    int c = 0;
    while (exp_hdr.size() > 0 && c < B) begin
      bit rdy;
      rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(1) == 1);
      m_hdr_ready = rdy;
      #1;
      if (m_hdr_valid) begin
        if (held) begin
          chk("hdr_hold_va", m_hdr_reth_vaddr, sva);
          chk("hdr_hold_fields",
              64'({m_hdr_opcode, m_hdr_psn, m_hdr_seg_length,
                   m_hdr_has_reth, m_hdr_has_immdt}), 64'(smisc));
        end
        chk("meta_rdy_busy", 64'(s_dma_meta_ready), 64'd0);
        if (stall_left > 0) begin
          stall_left--;
          chk("stall_tready", 64'(s_axis_tready), 64'd0);
        end
        if (rdy) begin
          hdr_t e;
          e = exp_hdr.pop_front();
          chk("hdr_opcode", 64'(m_hdr_opcode), 64'(e.op));
          chk("hdr_psn", 64'(m_hdr_psn), 64'(e.psn));
          chk("hdr_seglen", 64'(m_hdr_seg_length), 64'(e.len));
          chk("hdr_has_reth", 64'(m_hdr_has_reth), 64'(e.reth));
          chk("hdr_vaddr", m_hdr_reth_vaddr, e.va);
          chk("hdr_reth_len", 64'(m_hdr_reth_length), 64'(g_len));
          chk("hdr_has_immdt", 64'(m_hdr_has_immdt), 64'(e.immf));
          chk("hdr_dest_qp", 64'(m_hdr_dest_qp), 64'(g_qpn));
          chk("hdr_ip", 64'(m_hdr_ip_addr), 64'(g_ip));
          if (e.reth)
            chk("hdr_rkey", 64'(m_hdr_reth_rkey), 64'(g_rkey));
          if (e.immf)
            chk("hdr_immdt", 64'(m_hdr_immdt), 64'(g_immd));
          held = 0;
        end else begin
          held  = 1;
          sva   = m_hdr_reth_vaddr;
          smisc = {m_hdr_opcode, m_hdr_psn, m_hdr_seg_length,
                   m_hdr_has_reth, m_hdr_has_immdt};
        end
      end else begin
        held = 0;
      end
      @(negedge clk);
      c++;
    end
    m_hdr_ready = 1'b0;
    chk("hdr_left", 64'(exp_hdr.size()), 64'd0);
  endtask

  task automatic pl_sink();
    int c = 0;
    while (exp_beats.size() > 0 && c < B) begin
      m_axis_tready = ($urandom_range(1) == 1);
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        beat_t e;
        logic [63:0] msk;
        e = exp_beats.pop_front();
        for (int k = 0; k < 8; k++)
          msk[k*8 +: 8] = {8{m_axis_tkeep[k]}};
        chk("pl_keep", 64'(m_axis_tkeep), 64'(e.keep));
        chk("pl_data", m_axis_tdata & msk, e.data);
        chk("pl_last", 64'(m_axis_tlast), 64'(e.last));
        chk("pl_bad", 64'(m_axis_tuser), 64'(e.user[0]));
      end
      @(negedge clk);
      c++;
    end
    m_axis_tready = 1'b0;
    chk("beats_left", 64'(exp_beats.size()), 64'd0);
  endtask

  task automatic run_xfer(input bit wr, input int unsigned len,
                          input int unsigned pmtu,
                          input logic [23:0] psn,
                          input logic [63:0] addr, input bit imm,
                          input logic [31:0] immd, input int stall);
    g_qpn  = 24'($urandom);
    g_ip   = $urandom;
    g_rkey = $urandom;
    g_len  = len;
    g_immd = immd;
    exp_hdr.delete();
    exp_beats.delete();
    src_beats.delete();
    build_model(wr, len, pmtu, psn, addr, imm);
    stall_left = stall;
    @(negedge clk);
    fork
      meta_drv(wr, len, psn, addr, imm);
      src_drv();
      hdr_sink();
      pl_sink();
    join
    #1;
    chk("idle_meta_rdy", 64'(s_dma_meta_ready), 64'd1);
  endtask

  initial begin
    #3;
    chk("rst_meta_rdy", 64'(s_dma_meta_ready), 64'd0);
    chk("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_meta_rdy", 64'(s_dma_meta_ready), 64'd1);

    run_xfer(1, 1024, 256, 24'h000010, 64'h1000, 0, 32'h0, 0);
    run_xfer(0, 100, 256, 24'h000123, 64'h0, 1, 32'hDEADBEEF, 0);
    run_xfer(0, 400, 256, 24'hFFFFFF, 64'h2000, 0, 32'h0, 0);
    run_xfer(1, 512, 256, 24'h000200, 64'h8000, 0, 32'h0, 10);
    run_xfer(1, 768, 256, 24'h000300, 64'h4000, 1, 32'h12345678, 0);
    run_xfer(0, 0, 256, 24'h000400, 64'h0, 0, 32'h0, 0);

    // Reset while a segment is in its payload phase
    @(negedge clk);
    s_dma_meta_valid = 1'b1;
    s_trasfer_type   = 1'b1;
    s_dma_length     = 32'd512;
    s_rem_psn        = 24'h000055;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        #1;
        seen = s_dma_meta_ready;
        @(negedge clk);
      end
      s_dma_meta_valid = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'h1122334455667788;
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = {13'd256, 2'b00};
      m_hdr_ready   = 1'b1;
      m_axis_tready = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        #1;
        seen = m_axis_tvalid;
      end
      chk("rst_reach_payload", 64'(seen), 64'd1);
    end
    m_axis_tready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_meta_rdy", 64'(s_dma_meta_ready), 64'd0);
    chk("mid_rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    m_hdr_ready   = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerst_meta_rdy", 64'(s_dma_meta_ready), 64'd1);
    run_xfer(1, 512, 256, 24'h000777, 64'h9000, 1, 32'hCAFEF00D, 0);

    for (int t = 0; t < 15; t++) begin
      run_xfer(1'($urandom_range(1)),
               $urandom_range(2500),
               256 << $urandom_range(2),
               24'($urandom),
               {$urandom, $urandom},
               1'($urandom_range(1)),
               $urandom,
               ($urandom_range(3) == 0) ? 4 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
